det_seq: RTL and testbench

- Sequential signed determinant engine for 2x2 or 3x3 matrices, selected per operation.
- Element width and result width are parametrised.
- Uses a single 3-input product-and-accumulate datapath, one cofactor term per clock, with a start/busy/done handshake.
- Sits in the matrix coprocessor datapath behind the operation decoder.
- Provides a full-precision result plus a truncated or saturated narrow result with an overflow flag.

---
 rtl/det_seq.sv | 119 +++++++++++
 tb/tb_det_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/det_seq.sv
// Sequential signed 2x2/3x3 determinant: one cofactor product per clock into a
// full-width accumulator, then a wrapped or clamped narrow result.
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | accumulating term k each clock
//   DONE  | one-cycle result strobe; start here chains the next operation
module det_seq #(
  parameter int DW  = 8,
  parameter int OW  = 8,
  parameter int SAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              size,
  input  logic [9*DW-1:0]   m,
  output logic              busy,
  output logic              done,
  output logic [OW-1:0]     det,
  output logic [3*DW+2:0]   det_full,
  output logic              ovf
);

  localparam int FW = 3*DW+3;
  localparam logic signed [FW-1:0] MAXV = {{(FW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [FW-1:0] MINV = {{(FW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic signed [FW-1:0] ONE  = {{(FW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state, state_nxt;
  logic [9*DW-1:0]        m_q;
  logic                   size_q;
  logic [2:0]             k;
  logic signed [FW-1:0]   acc;

  logic signed [DW-1:0]   a [9];
  logic [2:0]             t;
  logic [3:0]             i0, i1, i2;
  logic signed [FW-1:0]   fa, fb, fc, prod, term, acc_nxt;
  logic                   last, ovf_nxt;
  logic [OW-1:0]          det_nxt;

  for (genvar i = 0; i < 9; i++) begin : g_elem
    assign a[i] = m_q[(8-i)*DW +: DW];
  end

  // 2x2 reuses the 3x3 k0 and k4 index sets with the third factor forced to +1
  always_comb begin
    t = size_q ? k : ((k == 3'd0) ? 3'd0 : 3'd4);
    i0 = 4'd0; i1 = 4'd4; i2 = 4'd8;
    case (t)
      3'd0: begin i0 = 4'd0; i1 = 4'd4; i2 = 4'd8; end
      3'd1: begin i0 = 4'd1; i1 = 4'd5; i2 = 4'd6; end
      3'd2: begin i0 = 4'd2; i1 = 4'd3; i2 = 4'd7; end
      3'd3: begin i0 = 4'd2; i1 = 4'd4; i2 = 4'd6; end
      3'd4: begin i0 = 4'd1; i1 = 4'd3; i2 = 4'd8; end
      3'd5: begin i0 = 4'd0; i1 = 4'd5; i2 = 4'd7; end
      default: begin i0 = 4'd0; i1 = 4'd4; i2 = 4'd8; end
    endcase
    fa = a[i0];
    fb = a[i1];
    fc = size_q ? FW'(a[i2]) : ONE;
    prod = fa * fb * fc;
    term = (t >= 3'd3) ? -prod : prod;
    acc_nxt = acc + term;
    last = size_q ? (k == 3'd5) : (k == 3'd1);
  end

  always_comb begin
    ovf_nxt = (acc_nxt > MAXV) || (acc_nxt < MINV);
    det_nxt = acc_nxt[OW-1:0];
    if (SAT != 0 && ovf_nxt)
      det_nxt = acc_nxt[FW-1] ? MINV[OW-1:0] : MAXV[OW-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      m_q      <= '0;
      size_q   <= 1'b0;
      k        <= '0;
      acc      <= '0;
      det      <= '0;
      det_full <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE || state == DONE) && start) begin
        m_q    <= m;
        size_q <= size;
        acc    <= '0;
        k      <= '0;
      end else if (state == CALC) begin
        acc <= acc_nxt;
        k   <= k + 3'd1;
        if (last) begin
          det_full <= acc_nxt;
          det      <= det_nxt;
          ovf      <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_det_seq.sv
// Directed bench for det_seq: wrap (SAT=0) and clamp (SAT=1) instances share
// all stimulus; expected results are hand-computed determinants.
module tb_det_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        size;
  logic [71:0] m;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [7:0]  det0, det1;
  logic signed [26:0] full0, full1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  det_seq #(.DW(8), .OW(8), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .size(size), .m(m),
    .busy(busy0), .done(done0), .det(det0), .det_full(full0), .ovf(ovf0));

  det_seq #(.DW(8), .OW(8), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .size(size), .m(m),
    .busy(busy1), .done(done1), .det(det1), .det_full(full1), .ovf(ovf1));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mk(input int a00, a01, a02, a10, a11, a12, a20, a21, a22);
    return {8'(a00), 8'(a01), 8'(a02), 8'(a10), 8'(a11), 8'(a12), 8'(a20), 8'(a21), 8'(a22)};
  endfunction

  // start pulse, count edges (sampling edge included) until done, then check results
  task automatic run_op(input string tag, input logic sz, input logic [71:0] mm,
                        input int lat, input bit perturb, input longint e_full,
                        input longint e_d0, input longint e_d1, input longint e_ovf);
    int n, nb;
    bit got;
    @(negedge clk);
    m = mm; size = sz; start = 1'b1;
    n = 0; nb = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (perturb) begin m = ~mm; size = ~sz; end
      if (done0) got = 1;
      else if (busy0) nb++;
    end
    chk({tag, ":lat"}, n, lat);
    chk({tag, ":busy"}, nb, lat - 1);
    chk({tag, ":full"}, full0, e_full);
    chk({tag, ":det_wrap"}, det0, e_d0);
    chk({tag, ":det_sat"}, det1, e_d1);
    chk({tag, ":ovf"}, ovf0, e_ovf);
    chk({tag, ":ovf_sat"}, ovf1, e_ovf);
    @(posedge clk); #1;
    chk({tag, ":done_pulse"}, done0, 0);
    chk({tag, ":hold_full"}, full0, e_full);
  endtask

  initial begin
    int cnt, first;
    int t[$];
    logic [71:0] m_id, m_a, m_d10;
    m_id  = mk(1, 0, 0, 0, 1, 0, 0, 0, 1);
    m_a   = mk(1, 2, 3, 4, 5, 6, 7, 8, 10);
    m_d10 = mk(10, 0, 0, 0, 10, 0, 0, 0, 10);

    rst = 1'b1; start = 1'b0; size = 1'b0; m = '1;
    repeat (3) @(negedge clk);
    chk("rst:busy", busy0, 0);
    chk("rst:done", done0, 0);
    chk("rst:full", full0, 0);
    chk("rst:det", det1, 0);
    chk("rst:ovf", ovf0, 0);
    rst = 1'b0;

    run_op("ident", 1'b1, m_id, 7, 0, 1, 8'h01, 8'h01, 0);
    run_op("m3", 1'b1, m_a, 7, 1, -3, 8'hFD, 8'hFD, 0);
    run_op("diag10", 1'b1, m_d10, 7, 1, 1000, 8'hE8, 8'h7F, 1);
    run_op("diagn10", 1'b1, mk(-10, 0, 0, 0, 10, 0, 0, 0, 10), 7, 0, -1000, 8'h18, 8'h80, 1);
    run_op("s2big", 1'b0, mk(-128, 0, 8'h55, 0, -128, 8'h55, 8'h55, 8'h55, 8'h55),
           3, 0, 16384, 8'h00, 8'h7F, 1);
    run_op("s2small", 1'b0, mk(3, 5, 9, 2, 4, 9, 9, 9, 9), 3, 1, 2, 8'h02, 8'h02, 0);

    // start held high: back-to-back operations, done every 7 cycles
    @(negedge clk);
    m = m_a; size = 1'b1; start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done0) begin
        t.push_back(i);
        chk("hold:full", full0, -3);
      end
    end
    start = 1'b0;
    chk("hold:count", t.size(), 4);
    for (int j = 0; j < 4; j++)
      chk($sformatf("hold:t%0d", j), (t.size() > j) ? t[j] : -1, 7 * (j + 1));
    repeat (10) @(posedge clk);

    // start pulses and size changes during CALC are ignored
    @(negedge clk);
    m = mk(2, 0, 0, 0, 3, 0, 0, 0, 5); size = 1'b1; start = 1'b1;
    cnt = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      start = (i <= 5) ? 1'(i % 2) : 1'b0;
      size = 1'b0;
      if (done0) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    chk("pulse:count", cnt, 1);
    chk("pulse:first", first, 7);
    chk("pulse:full", full0, 30);

    // reset in the middle of CALC
    run_op("prerst", 1'b1, m_d10, 7, 0, 1000, 8'hE8, 8'h7F, 1);
    @(negedge clk);
    m = m_id; size = 1'b1; start = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("rstmid:busy_pre", busy0, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid:busy", busy0, 0);
    chk("rstmid:done", done0, 0);
    chk("rstmid:det_wrap", det0, 0);
    chk("rstmid:det_sat", det1, 0);
    chk("rstmid:full", full0, 0);
    chk("rstmid:ovf", ovf1, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done0 || done1) cnt++;
    end
    chk("rstmid:no_done", cnt, 0);
    run_op("postrst", 1'b1, m_a, 7, 0, -3, 8'hFD, 8'hFD, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
